data_mem_mp: RTL

//  Parametrised multi-port data memory for the superscalar datapaths; next generation of the 2-port data memory.
//  N independent ports, byte write enables, cross-port same-cycle forwarding and deterministic write-write arbitration.
//  A reset-driven init sequencer fills the array, and collision flags and a counter report same-cycle write conflicts.

---
 rtl/data_mem_mp.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_mp.sv
// Multi-port data memory: byte-enabled writes, cross-port forwarding, write-write arbitration,
// reset-driven init fill and collision reporting. Define DMEM_REG_READ_EN for registered rdata.
module data_mem_mp #(
  parameter int unsigned NPORTS    = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned INIT_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS*ADDR_W-1:0]   addr,
  input  logic [NPORTS*DATA_W-1:0]   wdata,
  input  logic [NPORTS*DATA_W/8-1:0] be,
  input  logic [NPORTS-1:0]          we,
  input  logic [NPORTS-1:0]          re,
  output logic [NPORTS*DATA_W-1:0]   rdata,
  output logic                       ready,
  output logic [NPORTS-1:0]          collision,
  output logic [15:0]                collision_cnt
);

  localparam int unsigned IdxW   = $clog2(DEPTH);
  localparam int unsigned NBytes = DATA_W / 8;

  typedef enum logic {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic              init_we;
  logic [DATA_W-1:0] fill;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IdxW-1:0]   idx  [NPORTS];
  logic [NBytes-1:0] be_p [NPORTS];
  logic [DATA_W-1:0] wd   [NPORTS];
  logic [DATA_W-1:0] fwd  [NPORTS];
  logic [NPORTS-1:0] wr_en;

  logic [NPORTS-1:0] collision_q, collision_d;
  logic [15:0]       cnt_q;

  // Upper address bits alias onto the same word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr;

  // Init sequencer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    init_we = 1'b0;
    unique case (state_q)
      StInit: begin
        init_we = 1'b1;
        ptr_d   = ptr_q + IdxW'(1);
        if (ptr_q == IdxW'(DEPTH - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ready = (state_q == StRun);
  assign fill  = (INIT_MODE == 1) ? DATA_W'(ptr_q) : '0;

  // Per-port field slicing
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      idx[p]  = addr[p*ADDR_W +: IdxW];
      be_p[p] = be[p*NBytes +: NBytes];
      wd[p]   = wdata[p*DATA_W +: DATA_W];
    end
  end

  assign wr_en = we & {NPORTS{ready & ~rst}};

  // Ascending port order: later non-blocking assignments win, so the highest port owns a byte.
  always_ff @(posedge clk) begin
    if (init_we && !rst) begin
      mem[ptr_q] <= fill;
    end
    for (int p = 0; p < NPORTS; p++) begin
      for (int b = 0; b < NBytes; b++) begin
        if (wr_en[p] && be_p[p][b]) begin
          mem[idx[p]][b*8 +: 8] <= wd[p][b*8 +: 8];
        end
      end
    end
  end

  // Read value with forwarding from every other port; a port never sees its own write.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      fwd[p] = '0;
      if (ready && re[p]) begin
        fwd[p] = mem[idx[p]];
        for (int q = 0; q < NPORTS; q++) begin
          if (q != p && wr_en[q] && idx[q] == idx[p]) begin
            for (int b = 0; b < NBytes; b++) begin
              if (be_p[q][b]) begin
                fwd[p][b*8 +: 8] = wd[q][b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  // A port collides when any higher port overwrites one of its bytes in the same cycle.
  always_comb begin
    collision_d = '0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int q = p + 1; q < NPORTS; q++) begin
        if (wr_en[p] && wr_en[q] && idx[p] == idx[q] && |(be_p[p] & be_p[q])) begin
          collision_d[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_q <= '0;
      cnt_q       <= '0;
    end else begin
      collision_q <= collision_d;
      if (|collision_d && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign collision     = collision_q;
  assign collision_cnt = cnt_q;

`ifdef DMEM_REG_READ_EN
  logic [NPORTS*DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (re[p]) begin
          rdata_q[p*DATA_W +: DATA_W] <= fwd[p];
        end
      end
    end
  end

  assign rdata = rdata_q;
`else
  for (genvar gp = 0; gp < NPORTS; gp++) begin : g_rdata
    assign rdata[gp*DATA_W +: DATA_W] = fwd[gp];
  end
`endif

endmodule
